decode_forward_unit: RTL and testbench
======================================

// Module: decode_forward_unit
// PURPOSE
//  Parametrised forwarding/hazard unit for the decode stage. Tracks in-flight register writes in a
//  DEPTH-entry shift register, one entry per stage past decode. Gives every decode read port a
//  forwarding select: the youngest ready producer, or the register file. Raises a stall when a
//  needed result is not yet available (load-use).
//  Sits between the decode and ID/EX latches; drives decode operand muxes and the IF/ID hold.
// PARAMETERS
//  NB_REG            5  register address width
//  NUM_READ          2  decode read ports (channels)
//  DEPTH             3  tracked stages past decode (1=EX ... DEPTH=last stage before regfile write)
//  ALU_READY_STAGE   1  first stage index at which a non-load result is forwardable
//  LOAD_READY_STAGE  2  first stage index at which a load result is forwardable
//  NB_SEL            localparam = $clog2(DEPTH+1)
// PORTS
//  clock             in   1                clock, all state on rising edge
//  reset             in   1                asynchronous, active-high; clears all entries
//  i_issue_valid     in   1                instruction in decode wants to advance to EX
//  i_issue_reg_write in   1                that instruction writes a register
//  i_issue_is_load   in   1                that instruction is a load
//  i_issue_dest      in   NB_REG           its destination register
//  i_src_addr        in   NUM_READ*NB_REG  source register per read port (port p at [p*NB_REG +: NB_REG])
//  i_src_used        in   NUM_READ         port p actually consumes its operand
//  i_flush           in   1                kill the decode instruction (taken branch / jump)
//  o_fwd_sel         out  NUM_READ*NB_SEL  per port: 0 = register file, k = forward from stage k
//  o_stall           out  1                hold PC and IF/ID; bubble into EX
// BEHAVIOUR
//  - Entry k (1..DEPTH) holds {valid, dest, is_load}. valid is set only if reg_write=1 and dest!=0.
//  - Each clock: entry[k+1] <= entry[k] for k<DEPTH; entry[DEPTH] retires; entry[1] <= issue
//    if i_issue_valid & ~o_stall & ~i_flush, else bubble (valid=0).
//  - Ready(k) = valid & (is_load ? k>=LOAD_READY_STAGE : k>=ALU_READY_STAGE).
//  - Per port p, match(k) = i_src_used[p] & valid[k] & dest[k]==src[p] & src[p]!=0.
//  - Youngest match wins (lowest k). If it is ready, sel=k; if not ready, sel=0 and the port
//    requests a stall. No match: sel=0. Older matches are shadowed by a younger match, even a
//    non-ready one.
//  - o_stall = OR of port stall requests. o_stall and o_fwd_sel are combinational from the
//    entries and current inputs; there is no added latency.
//  - Register file write-through is required: a retiring entry needs no forwarding.
//  - Register 0 is never tracked and never forwarded.
//  - i_flush and o_stall in the same cycle: a bubble enters, and older entries still advance.
//  - A stall never freezes the tracker; older stages always drain, so a load-use stall clears
//    after (LOAD_READY_STAGE-1) cycles.
//  - Reset (also mid-stream): all valid=0 immediately; o_stall=0; o_fwd_sel=0 until the next issue.
// STRUCTURE
//  - Shared package decode_fwd_pkg: SEL_REGFILE=0 constant, entry struct {valid,dest,is_load},
//    and a function for NB_SEL.
//  - Sub-module fwd_port_match: one instance per read port via generate. It takes the entry
//    vector and one source, and returns {sel, stall_req}.
//  - The top level holds the shift register and the OR-reduce of stall requests.
// TESTING
//  1. add r3 issued; next cycle r3 is read on port 0 -> sel0=1, stall=0. Cycle after -> sel0=2.
//  2. lw r5 issued; next cycle r5 is read on port 1 -> stall=1 for one cycle, then sel1=2, stall=0.
//  3. add r4 then sub r4 back-to-back; r4 is read on both ports -> sel=1 on both ports (youngest).
//  4. Dest r0 with reg_write=1; r0 is read -> sel=0, stall=0 throughout.
//  5. lw r7 with i_flush=1 on the issue cycle; r7 is read next cycle -> no entry, sel=0, stall=0.
//  6. lw r2 in stage 1 and reset asserted asynchronously mid-cycle -> stall drops to 0 at once.
//     Entries are all invalid after reset.

Source files
------------

// File: rtl/decode_fwd_pkg.sv
// rtl/decode_fwd_pkg.sv - shared types and helpers for the decode forwarding unit
//
// SEL_REGFILE   : forwarding select value meaning "read the register file"
// ENTRY_DEST_W  : storage width of a tracked destination (holds any NB_REG up to this)
// fwd_entry_t   : one in-flight write {valid, dest, is_load}
// sel_width()   : width of a per-port forwarding select for a given tracker depth
package decode_fwd_pkg;

    localparam int SEL_REGFILE  = 0;
    localparam int ENTRY_DEST_W = 8;

    typedef struct packed {
        logic                    valid;
        logic [ENTRY_DEST_W-1:0] dest;
        logic                    is_load;
    } fwd_entry_t;

    // One code per stage plus the register-file code 0.
    function automatic int sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_port_match.sv
// rtl/fwd_port_match.sv - forwarding select and stall request for one decode read port
//
// entries   in   DEPTH x fwd_entry_t   tracker contents, index 1 = EX (youngest)
// src_addr  in   NB_REG                source register read by this port
// src_used  in   1                     port actually consumes its operand
// sel       out  NB_SEL                0 = register file, k = forward from stage k
// stall_req out  1                     youngest producer exists but is not ready yet
module fwd_port_match
    import decode_fwd_pkg::*;
#(
    parameter int NB_REG           = 5,
    parameter int DEPTH            = 3,
    parameter int ALU_READY_STAGE  = 1,
    parameter int LOAD_READY_STAGE = 2,
    parameter int NB_SEL           = 2
) (
    input  fwd_entry_t [DEPTH:1] entries,
    input  logic [NB_REG-1:0]    src_addr,
    input  logic                 src_used,
    output logic [NB_SEL-1:0]    sel,
    output logic                 stall_req
);

    logic [ENTRY_DEST_W-1:0] src_ext;
    logic                    src_nonzero;

    assign src_ext     = ENTRY_DEST_W'(src_addr);
    assign src_nonzero = (src_addr != '0);

    // Scan oldest to youngest so the youngest match overwrites the result.
    // A non-ready younger match therefore shadows a ready older one.
    always_comb begin
        sel       = NB_SEL'(SEL_REGFILE);
        stall_req = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (src_used && src_nonzero && entries[k].valid &&
                (entries[k].dest == src_ext)) begin
                if (entries[k].is_load ? (k >= LOAD_READY_STAGE)
                                       : (k >= ALU_READY_STAGE)) begin
                    sel       = NB_SEL'(k);
                    stall_req = 1'b0;
                end else begin
                    sel       = NB_SEL'(SEL_REGFILE);
                    stall_req = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decode_forward_unit.sv
// rtl/decode_forward_unit.sv - in-flight write tracker, per-port forwarding selects, load-use stall
//
// clock              in   1                 all state on rising edge
// reset              in   1                 asynchronous active-high, clears all entries
// i_issue_valid      in   1                 decode instruction wants to advance to EX
// i_issue_reg_write  in   1                 it writes a register
// i_issue_is_load    in   1                 it is a load
// i_issue_dest       in   NB_REG            its destination register
// i_src_addr         in   NUM_READ*NB_REG   source per port, port p at [p*NB_REG +: NB_REG]
// i_src_used         in   NUM_READ          port p consumes its operand
// i_flush            in   1                 kill the decode instruction
// o_fwd_sel          out  NUM_READ*NB_SEL   per port select, port p at [p*NB_SEL +: NB_SEL]
// o_stall            out  1                 hold PC and IF/ID, bubble into EX
module decode_forward_unit
    import decode_fwd_pkg::*;
#(
    parameter int NB_REG           = 5,
    parameter int NUM_READ         = 2,
    parameter int DEPTH            = 3,
    parameter int ALU_READY_STAGE  = 1,
    parameter int LOAD_READY_STAGE = 2
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   i_issue_valid,
    input  logic                                   i_issue_reg_write,
    input  logic                                   i_issue_is_load,
    input  logic [NB_REG-1:0]                      i_issue_dest,
    input  logic [NUM_READ*NB_REG-1:0]             i_src_addr,
    input  logic [NUM_READ-1:0]                    i_src_used,
    input  logic                                   i_flush,
    output logic [NUM_READ*sel_width(DEPTH)-1:0]   o_fwd_sel,
    output logic                                   o_stall
);

    localparam int NB_SEL = sel_width(DEPTH);

    fwd_entry_t [DEPTH:1] entries;
    fwd_entry_t           issue_entry;
    logic [NUM_READ-1:0]  stall_req;

    // A stalled or flushed decode instruction enters as a bubble; register 0
    // is never tracked so it can never be forwarded.
    always_comb begin
        issue_entry         = '0;
        issue_entry.valid   = i_issue_valid && !o_stall && !i_flush &&
                              i_issue_reg_write && (i_issue_dest != '0);
        issue_entry.dest    = ENTRY_DEST_W'(i_issue_dest);
        issue_entry.is_load = i_issue_is_load;
    end

    // The tracker always advances, even while stalled, so older producers
    // drain and a load-use stall resolves on its own.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entries <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                entries[k] <= entries[k-1];
            end
            entries[1] <= issue_entry;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_port
        fwd_port_match #(
            .NB_REG           (NB_REG),
            .DEPTH            (DEPTH),
            .ALU_READY_STAGE  (ALU_READY_STAGE),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .NB_SEL           (NB_SEL)
        ) u_match (
            .entries   (entries),
            .src_addr  (i_src_addr[p*NB_REG +: NB_REG]),
            .src_used  (i_src_used[p]),
            .sel       (o_fwd_sel[p*NB_SEL +: NB_SEL]),
            .stall_req (stall_req[p])
        );
    end

    assign o_stall = |stall_req;

endmodule

// File: tb/tb_decode_forward_unit.sv
// tb/tb_decode_forward_unit.sv - directed self-checking bench for decode_forward_unit
module tb_decode_forward_unit;

    localparam int NB_REG   = 5;
    localparam int NUM_READ = 2;
    localparam int NB_SEL   = 2;

    logic                       clock;
    logic                       reset;
    logic                       i_issue_valid;
    logic                       i_issue_reg_write;
    logic                       i_issue_is_load;
    logic [NB_REG-1:0]          i_issue_dest;
    logic [NUM_READ*NB_REG-1:0] i_src_addr;
    logic [NUM_READ-1:0]        i_src_used;
    logic                       i_flush;
    logic [NUM_READ*NB_SEL-1:0] o_fwd_sel;
    logic                       o_stall;

    int errors;
    int checks;

    decode_forward_unit #(
        .NB_REG           (NB_REG),
        .NUM_READ         (NUM_READ),
        .DEPTH            (3),
        .ALU_READY_STAGE  (1),
        .LOAD_READY_STAGE (2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .i_issue_valid     (i_issue_valid),
        .i_issue_reg_write (i_issue_reg_write),
        .i_issue_is_load   (i_issue_is_load),
        .i_issue_dest      (i_issue_dest),
        .i_src_addr        (i_src_addr),
        .i_src_used        (i_src_used),
        .i_flush           (i_flush),
        .o_fwd_sel         (o_fwd_sel),
        .o_stall           (o_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    wire [NB_SEL-1:0] sel0 = o_fwd_sel[0 +: NB_SEL];
    wire [NB_SEL-1:0] sel1 = o_fwd_sel[NB_SEL +: NB_SEL];

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // one unit later, well away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        i_issue_valid     = 1'b0;
        i_issue_reg_write = 1'b0;
        i_issue_is_load   = 1'b0;
        i_issue_dest      = '0;
        i_src_addr        = '0;
        i_src_used        = '0;
        i_flush           = 1'b0;
    endtask

    task automatic issue(input logic [NB_REG-1:0] dest, input logic is_load, input logic flush);
        idle();
        i_issue_valid     = 1'b1;
        i_issue_reg_write = 1'b1;
        i_issue_is_load   = is_load;
        i_issue_dest      = dest;
        i_flush           = flush;
    endtask

    task automatic read(input logic [NB_REG-1:0] s0, input logic u0,
                        input logic [NB_REG-1:0] s1, input logic u1);
        i_src_addr = {s1, s0};
        i_src_used = {u1, u0};
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        read(5'd1, 1'b1, 5'd2, 1'b1);
        #1;
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", o_stall); end
        checks++;
        if (o_fwd_sel !== 4'd0) begin errors++; $display("FAIL reset_sel got=%0h exp=0", o_fwd_sel); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_forward();
        drain();
        issue(5'd3, 1'b0, 1'b0);
        tick();
        idle();
        read(5'd3, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if (sel0 !== 2'd1) begin errors++; $display("FAIL alu_stage1_sel got=%0d exp=1", sel0); end
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL alu_stage1_stall got=%0b exp=0", o_stall); end
        tick();
        checks++;
        if (sel0 !== 2'd2) begin errors++; $display("FAIL alu_stage2_sel got=%0d exp=2", sel0); end
        tick();
        checks++;
        if (sel0 !== 2'd3) begin errors++; $display("FAIL alu_stage3_sel got=%0d exp=3", sel0); end
        tick();
        checks++;
        if (sel0 !== 2'd0) begin errors++; $display("FAIL alu_retired_sel got=%0d exp=0", sel0); end
    endtask

    task automatic test_load_use();
        drain();
        issue(5'd5, 1'b1, 1'b0);
        tick();
        // The dependent instruction also writes r6 but must be held back.
        issue(5'd6, 1'b0, 1'b0);
        read(5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        checks++;
        if (o_stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got=%0b exp=1", o_stall); end
        checks++;
        if (sel1 !== 2'd0) begin errors++; $display("FAIL load_use_sel got=%0d exp=0", sel1); end
        tick();
        idle();
        read(5'd6, 1'b1, 5'd5, 1'b1);
        #1;
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL load_ready_stall got=%0b exp=0", o_stall); end
        checks++;
        if (sel1 !== 2'd2) begin errors++; $display("FAIL load_ready_sel got=%0d exp=2", sel1); end
        checks++;
        if (sel0 !== 2'd0) begin errors++; $display("FAIL stalled_issue_bubble got=%0d exp=0", sel0); end
    endtask

    task automatic test_back_to_back();
        drain();
        issue(5'd4, 1'b0, 1'b0);
        tick();
        issue(5'd4, 1'b0, 1'b0);
        tick();
        idle();
        read(5'd4, 1'b1, 5'd4, 1'b1);
        #1;
        checks++;
        if (o_fwd_sel !== {2'd1, 2'd1}) begin errors++; $display("FAIL youngest_both got=%0h exp=5", o_fwd_sel); end
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL youngest_stall got=%0b exp=0", o_stall); end
    endtask

    task automatic test_shadow();
        drain();
        issue(5'd9, 1'b0, 1'b0);
        tick();
        issue(5'd9, 1'b1, 1'b0);
        tick();
        idle();
        read(5'd9, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if (o_stall !== 1'b1) begin errors++; $display("FAIL shadow_stall got=%0b exp=1", o_stall); end
        checks++;
        if (sel0 !== 2'd0) begin errors++; $display("FAIL shadow_sel got=%0d exp=0", sel0); end
    endtask

    task automatic test_reg_zero();
        drain();
        issue(5'd0, 1'b0, 1'b0);
        tick();
        idle();
        read(5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        checks++;
        if (o_fwd_sel !== 4'd0 || o_stall !== 1'b0) begin
            errors++; $display("FAIL r0_stage1 sel=%0h stall=%0b exp sel=0 stall=0", o_fwd_sel, o_stall);
        end
        tick();
        checks++;
        if (o_fwd_sel !== 4'd0 || o_stall !== 1'b0) begin
            errors++; $display("FAIL r0_stage2 sel=%0h stall=%0b exp sel=0 stall=0", o_fwd_sel, o_stall);
        end
    endtask

    task automatic test_unused_port();
        drain();
        issue(5'd8, 1'b0, 1'b0);
        tick();
        idle();
        read(5'd8, 1'b0, 5'd8, 1'b1);
        #1;
        checks++;
        if (o_fwd_sel !== {2'd1, 2'd0}) begin errors++; $display("FAIL unused_port got=%0h exp=4", o_fwd_sel); end
    endtask

    task automatic test_flush();
        drain();
        issue(5'd7, 1'b1, 1'b1);
        tick();
        idle();
        read(5'd7, 1'b1, 5'd7, 1'b1);
        #1;
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0b exp=0", o_stall); end
        checks++;
        if (o_fwd_sel !== 4'd0) begin errors++; $display("FAIL flush_sel got=%0h exp=0", o_fwd_sel); end
    endtask

    task automatic test_async_reset();
        drain();
        issue(5'd2, 1'b1, 1'b0);
        tick();
        idle();
        read(5'd2, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if (o_stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got=%0b exp=1", o_stall); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL async_reset_stall got=%0b exp=0", o_stall); end
        checks++;
        if (sel0 !== 2'd0) begin errors++; $display("FAIL async_reset_sel got=%0d exp=0", sel0); end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (o_stall !== 1'b0 || sel0 !== 2'd0) begin
            errors++; $display("FAIL post_reset sel=%0d stall=%0b exp sel=0 stall=0", sel0, o_stall);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_back_to_back();
        test_shadow();
        test_reg_zero();
        test_unused_port();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
